hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 16 +
 rtl/hazard_scoreboard_if.sv | 23 ++
 rtl/hazard_match.sv | 25 ++
 rtl/hazard_scoreboard.sv | 48 ++++
 tb/tb_hazard_scoreboard.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared entry type, forward encoding and default parameters.
package hazard_scoreboard_pkg;
  localparam int REG_BITS_DEF = 5;
  localparam int DEPTH_DEF = 3;
  localparam int LOAD_LAT_DEF = 2;
  localparam int MAX_REG_BITS = 8;
  localparam int FWD_RF = 0;
  typedef logic [2:0] stage_t;
  // dest is sized for the widest supported register address; narrower ids are zero-extended
  typedef struct packed {
    logic valid;
    logic [MAX_REG_BITS-1:0] dest;
    logic reg_write;
    stage_t ready;
  } entry_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage inputs and pipeline control outputs of the scoreboard.
interface hazard_scoreboard_if import hazard_scoreboard_pkg::*; #(
  parameter int REG_BITS = REG_BITS_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  localparam int FW = $clog2(DEPTH + 1);
  logic id_valid;
  logic [REG_BITS-1:0] id_rs, id_rt, id_rd;
  logic id_use_rs, id_use_rt, id_reg_write, id_mem_read, id_branch, branch_taken, stall_ext;
  logic pc_write, ifid_write, ctrl_sel, if_flush;
  logic [FW-1:0] fwd_a, fwd_b;
  logic [15:0] stall_count;
  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_reg_write, id_mem_read,
           id_branch, branch_taken, stall_ext,
    input pc_write, ifid_write, ctrl_sel, if_flush, fwd_a, fwd_b, stall_count
  );
  modport slave (
    input id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_reg_write, id_mem_read,
          id_branch, branch_taken, stall_ext,
    output pc_write, ifid_write, ctrl_sel, if_flush, fwd_a, fwd_b, stall_count
  );
endinterface

// File: rtl/hazard_match.sv
// hazard_match: youngest in-flight producer of one source register (smallest stage wins).
module hazard_match import hazard_scoreboard_pkg::*; #(
  parameter int REG_BITS = REG_BITS_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  entry_t [DEPTH:1]    tbl,
  input  logic [REG_BITS-1:0] src,
  input  logic                use_src,
  output logic                hit,
  output stage_t              stage,
  output stage_t              ready
);
  always_comb begin
    hit = 1'b0;
    stage = '0;
    ready = '0;
    for (int k = DEPTH; k >= 1; k--)
      if (use_src && src != '0 && tbl[k].valid && tbl[k].reg_write &&
          tbl[k].dest == MAX_REG_BITS'(src)) begin
        hit = 1'b1;
        stage = stage_t'(k);
        ready = tbl[k].ready;
      end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks post-ID producers, raises load-use/branch stalls and registers forward selects.
module hazard_scoreboard import hazard_scoreboard_pkg::*; #(
  parameter int REG_BITS = REG_BITS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave bus
);
  localparam int FW = $clog2(DEPTH + 1);
  entry_t [DEPTH:1] tbl;
  entry_t ent;
  logic hit_a, hit_b, hazard, issue;
  stage_t k_a, k_b, r_a, r_b;
  logic [FW-1:0] nf_a, nf_b;
  hazard_match #(.REG_BITS(REG_BITS), .DEPTH(DEPTH)) u_match_a (
    .tbl(tbl), .src(bus.id_rs), .use_src(bus.id_use_rs), .hit(hit_a), .stage(k_a), .ready(r_a)
  );
  hazard_match #(.REG_BITS(REG_BITS), .DEPTH(DEPTH)) u_match_b (
    .tbl(tbl), .src(bus.id_rt), .use_src(bus.id_use_rt), .hit(hit_b), .stage(k_b), .ready(r_b)
  );
  // branches compare in ID, so they also wait out the stage where the value is produced
  assign hazard = bus.id_valid & ((hit_a & (k_a < r_a)) | (hit_b & (k_b < r_b)) |
                  (bus.id_branch & ((hit_a & (k_a <= r_a)) | (hit_b & (k_b <= r_b)))));
  assign issue = bus.id_valid & ~hazard;
  assign bus.pc_write = ~(hazard | bus.stall_ext);
  assign bus.ifid_write = ~(hazard | bus.stall_ext);
  assign bus.ctrl_sel = hazard & ~bus.stall_ext;
  assign bus.if_flush = bus.id_branch & bus.branch_taken & ~hazard & ~bus.stall_ext;
  assign ent = issue ? entry_t'{valid: 1'b1, dest: MAX_REG_BITS'(bus.id_rd),
                                reg_write: bus.id_reg_write,
                                ready: bus.id_mem_read ? stage_t'(LOAD_LAT) : stage_t'(1)} : '0;
  assign nf_a = (issue && hit_a && int'(k_a) < DEPTH) ? FW'(k_a + 3'd1) : FW'(FWD_RF);
  assign nf_b = (issue && hit_b && int'(k_b) < DEPTH) ? FW'(k_b + 3'd1) : FW'(FWD_RF);
  always_ff @(posedge clk)
    if (rst) begin
      tbl <= '0;
      bus.fwd_a <= FW'(FWD_RF);
      bus.fwd_b <= FW'(FWD_RF);
      bus.stall_count <= '0;
    end else if (!bus.stall_ext) begin
      tbl <= {tbl[DEPTH-1:1], ent};
      bus.fwd_a <= nf_a;
      bus.fwd_b <= nf_b;
      if (hazard && bus.stall_count != 16'hFFFF) bus.stall_count <= bus.stall_count + 16'd1;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table plus reset and counter-saturation sequences.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    int v, rs, rt, urs, urt, rd, rw, mr, br, bt, sx;
    int pw, cs, fl, fa, fb, sc;
  } vec_t;
  vec_t vt[29];
  hazard_scoreboard_if #(.REG_BITS(5), .DEPTH(3)) m();
  hazard_scoreboard_if #(.REG_BITS(5), .DEPTH(7)) s();
  hazard_scoreboard #(.REG_BITS(5), .DEPTH(3), .LOAD_LAT(2)) dut (.clk(clk), .rst(rst), .bus(m.slave));
  // deep pipeline lets the saturation run stall 6 of every 7 cycles
  hazard_scoreboard #(.REG_BITS(5), .DEPTH(7), .LOAD_LAT(6)) sat (.clk(clk), .rst(rst), .bus(s.slave));

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    m.id_valid = 1'(x.v);
    m.id_rs = 5'(x.rs);
    m.id_rt = 5'(x.rt);
    m.id_use_rs = 1'(x.urs);
    m.id_use_rt = 1'(x.urt);
    m.id_rd = 5'(x.rd);
    m.id_reg_write = 1'(x.rw);
    m.id_mem_read = 1'(x.mr);
    m.id_branch = 1'(x.br);
    m.branch_taken = 1'(x.bt);
    m.stall_ext = 1'(x.sx);
  endtask

  task automatic s_drive(input int v, input int rs, input int urs, input int rd, input int rw,
                         input int mr, input int br);
    s.id_valid = 1'(v);
    s.id_rs = 5'(rs);
    s.id_use_rs = 1'(urs);
    s.id_rd = 5'(rd);
    s.id_reg_write = 1'(rw);
    s.id_mem_read = 1'(mr);
    s.id_branch = 1'(br);
  endtask

  task automatic check_row(input string nm, input vec_t x);
    chk({nm, " pc_write"}, int'(m.pc_write), x.pw);
    chk({nm, " ifid_write"}, int'(m.ifid_write), x.pw);
    chk({nm, " ctrl_sel"}, int'(m.ctrl_sel), x.cs);
    chk({nm, " if_flush"}, int'(m.if_flush), x.fl);
    chk({nm, " fwd_a"}, int'(m.fwd_a), x.fa);
    chk({nm, " fwd_b"}, int'(m.fwd_b), x.fb);
    chk({nm, " stall_count"}, int'(m.stall_count), x.sc);
  endtask

  initial begin
    //        v rs rt us ut rd rw mr br bt sx  pw cs fl fa fb sc
    vt = '{
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0},
      '{1, 9, 9, 1, 1, 0, 0, 0, 1, 1, 0,  1, 0, 1, 0, 0, 0},
      '{1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0},
      '{1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0},
      '{1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 3, 0, 1},
      '{1, 1, 1, 1, 1, 5, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1},
      '{1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1},
      '{1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 2, 2, 1},
      '{1, 0, 0, 1, 1, 7, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1},
      '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1},
      '{1, 1, 7, 1, 1, 0, 0, 0, 1, 1, 0,  0, 1, 0, 0, 0, 1},
      '{1, 1, 7, 1, 1, 0, 0, 0, 1, 1, 0,  1, 0, 1, 0, 0, 2},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 3, 0, 2},
      '{1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 2},
      '{1, 1, 7, 1, 1, 0, 0, 0, 1, 1, 0,  0, 1, 0, 0, 0, 2},
      '{1, 1, 7, 1, 1, 0, 0, 0, 1, 1, 0,  0, 1, 0, 0, 0, 3},
      '{1, 1, 7, 1, 1, 0, 0, 0, 1, 1, 0,  1, 0, 1, 0, 0, 4},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 4},
      '{1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 4},
      '{1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 4},
      '{1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 4},
      '{1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 4},
      '{1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 4},
      '{1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 5},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 3, 0, 5},
      '{1, 9, 9, 1, 1, 0, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 5},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 5}
    };
    drive(vt[0]);
    s_drive(0, 0, 0, 0, 0, 0, 0);
    s.id_rt = '0;
    s.id_use_rt = 1'b0;
    s.branch_taken = 1'b0;
    s.stall_ext = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 29; i++) begin
      drive(vt[i]);
      #2;
      check_row($sformatf("row%0d", i), vt[i]);
      @(negedge clk);
    end
    // reset lands on a load-use stall while a forward is pending
    drive('{1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    @(negedge clk);
    drive('{1, 5, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    #2;
    chk("pre-reset lw pc_write", int'(m.pc_write), 1);
    @(negedge clk);
    drive('{1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    #2;
    chk("pre-reset ctrl_sel", int'(m.ctrl_sel), 1);
    chk("pre-reset fwd_a", int'(m.fwd_a), 2);
    chk("pre-reset stall_count", int'(m.stall_count), 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("post-reset pc_write", int'(m.pc_write), 1);
    chk("post-reset ctrl_sel", int'(m.ctrl_sel), 0);
    chk("post-reset fwd_a", int'(m.fwd_a), 0);
    chk("post-reset fwd_b", int'(m.fwd_b), 0);
    chk("post-reset stall_count", int'(m.stall_count), 0);
    drive(vt[0]);
    for (int g = 0; g < 10924; g++) begin
      @(negedge clk);
      s_drive(1, 0, 0, 1, 1, 1, 0);
      if (g == 1) begin
        #2;
        chk("sat count g1", int'(s.stall_count), 6);
      end
      if (g == 10922) begin
        #2;
        chk("sat count g10922", int'(s.stall_count), 65532);
      end
      repeat (6) begin
        @(negedge clk);
        s_drive(1, 1, 1, 0, 0, 0, 1);
      end
    end
    @(negedge clk);
    s_drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("sat count final", int'(s.stall_count), 65535);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
